shift_unit: RTL and testbench
=============================

# shift_unit

Parametrised multi-mode shifter for the ALU bit-shift group and the successor to the single-cycle 20-bit right shifter. It accepts an operand, a shift amount and a mode over a valid/ready handshake, then shifts iteratively, one bit position per clock. It returns the result with carry-out and zero flags over a second valid/ready handshake. Supported modes are logical left/right, arithmetic right, and rotate left/right.

## Interface
- WIDTH, 20, operand/result width in bits (≥2)
- AMT_W, 5, shift-amount width; maximum amount is 2^AMT_W−1
- clk  in  1  clock; all state updates on posedge clk
- rst_n  in  1  reset; synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_data  in  WIDTH  operand
- in_amt  in  AMT_W  number of bit positions to shift
- in_mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101–111 reserved
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  shifted result
- out_carry  out  1  last bit shifted or rotated out
- out_zero  out  1  out_data == 0

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, latch in_data into the work register, in_amt into the counter, and in_mode.
  - Clear carry, then go to SHIFT.
- SHIFT:
  - If counter==0, go to DONE.
  - Otherwise perform one single-bit step and decrement the counter.
- DONE:
  - out_valid=1; out_data, out_carry and out_zero are held stable.
  - On out_ready, go to IDLE.
- Single-bit steps, for work register w:
  - LSL: carry←w[W−1]; w←{w[W−2:0],0}
  - LSR: carry←w[0]; w←{0,w[W−1:1]}
  - ASR: carry←w[0]; w←{w[W−1],w[W−1:1]}
  - ROL: carry←w[W−1]; w←{w[W−2:0],w[W−1]}
  - ROR: carry←w[0]; w←{w[0],w[W−1:1]}
- Reserved modes: no shift is performed. The counter is forced to 0 at accept, so out_data=in_data and out_carry=0.
- Amounts are never reduced or saturated; the unit iterates the full in_amt.
  - Logical shifts with amount ≥ WIDTH yield 0.
  - ASR with amount ≥ WIDTH yields all copies of the sign bit.
  - Rotates wrap naturally; for example, an amount of WIDTH returns the operand unchanged.
- Amount 0: out_data=in_data, out_carry=0.
- out_zero is derived from the work register and is valid whenever out_valid=1.
- in_ready=0 in SHIFT and DONE. A new request is never accepted in the same cycle a result is consumed.
- Inputs other than on the accept cycle are ignored.

## Timing
- Reset (rst_n low at a posedge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, out_zero=1, counter=0.
  - Reset is honoured in any state and aborts an in-progress shift with no result.
- Accept at edge N: SHIFT is entered after N, and shifts occur at edges N+1…N+k (k = effective amount).
- DONE is entered at edge N+k+1; out_valid is high from then on. Latency is k+1 cycles, giving a range of 1 to 2^AMT_W.
- Result consumed at the first edge with out_valid&&out_ready. in_ready rises after that edge, so the next accept is possible at the following edge.
- Minimum request-to-request period: k+3 cycles.
- out_valid stays high and outputs stay constant for any number of out_ready-low cycles.
- A combinational path from out_ready to in_ready is forbidden.

## Test plan
- Reset: hold rst_n low 2 cycles, then release → in_ready=1, out_valid=0, out_data=0x00000, out_zero=1.
- LSR: 0xABCDE by 4 → out_data=0x0ABCD, out_carry=1, out_zero=0, out_valid first high 5 cycles after accept.
- ASR: 0x80000 by 3 → 0xF0000, carry 0. ROL: 0x80001 by 1 → 0x00003, carry 1. ROR: 0x12345 by 20 → 0x12345.
- Boundaries:
  - LSL 0x00001 by 20 → 0x00000, out_carry=1, out_zero=1.
  - Amount 0 on 0x5A5A5 → 0x5A5A5, carry 0, latency 1.
  - Reserved mode 111 → operand returned unchanged.
- Backpressure: hold out_ready low 4 cycles after out_valid → outputs stable, in_ready=0. Assert out_ready → in_ready=1 on the next cycle.
- Reset mid-op: start ROR by 31, drop rst_n at cycle 10 → IDLE, no out_valid. A subsequent LSL 0x00003 by 2 → 0x0000C.

Source files
------------

// File: rtl/shift_unit_if.sv
// Request/response bundle for shift_unit: operand, amount and mode in,
// result with carry/zero flags out, each over its own valid/ready pair.
interface shift_unit_if #(
    parameter int WIDTH = 20,
    parameter int AMT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_carry, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_carry, out_zero
    );
endinterface

// File: rtl/shift_unit.sv
// Iterative multi-mode shifter: one bit position per clock, IDLE -> SHIFT -> DONE.
// Modes: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR; 5-7 return the operand unshifted.
module shift_unit #(
    parameter int WIDTH = 20,
    parameter int AMT_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    shift_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] M_LSL = 3'd0;
    localparam logic [2:0] M_LSR = 3'd1;
    localparam logic [2:0] M_ASR = 3'd2;
    localparam logic [2:0] M_ROL = 3'd3;
    localparam logic [2:0] M_ROR = 3'd4;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_work;
    logic [AMT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic             r_carry;

    logic             w_accept;
    logic             w_step;
    logic [WIDTH-1:0] w_step_data;
    logic             w_step_carry;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_step   = (r_state == SHIFT) && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)     w_next_state = SHIFT;
            SHIFT:   if (r_cnt == '0)      w_next_state = DONE;
            DONE:    if (bus.out_ready)    w_next_state = IDLE;
            default:                       w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_step_data  = r_work;
        w_step_carry = r_carry;
        case (r_mode)
            M_LSL: begin
                w_step_carry = r_work[WIDTH-1];
                w_step_data  = {r_work[WIDTH-2:0], 1'b0};
            end
            M_LSR: begin
                w_step_carry = r_work[0];
                w_step_data  = {1'b0, r_work[WIDTH-1:1]};
            end
            M_ASR: begin
                w_step_carry = r_work[0];
                w_step_data  = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            end
            M_ROL: begin
                w_step_carry = r_work[WIDTH-1];
                w_step_data  = {r_work[WIDTH-2:0], r_work[WIDTH-1]};
            end
            M_ROR: begin
                w_step_carry = r_work[0];
                w_step_data  = {r_work[0], r_work[WIDTH-1:1]};
            end
            default: ;
        endcase
    end

    // Reserved modes load a zero count so SHIFT falls straight through to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_work  <= '0;
            r_cnt   <= '0;
            r_mode  <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_work  <= bus.in_data;
            r_cnt   <= (bus.in_mode > M_ROR) ? '0 : bus.in_amt;
            r_mode  <= bus.in_mode;
            r_carry <= 1'b0;
        end else if (w_step) begin
            r_work  <= w_step_data;
            r_carry <= w_step_carry;
            r_cnt   <= r_cnt - 1'b1;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_data  = r_work;
    assign bus.out_carry = r_carry;
    assign bus.out_zero  = (r_work == '0);
endmodule

// File: tb/tb_shift_unit.sv
// Directed vector bench for shift_unit: table of hand-computed results plus
// backpressure and mid-operation reset sequences.
module tb_shift_unit;
    localparam int WIDTH = 20;
    localparam int AMT_W = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    shift_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic [2:0]       mode;
        logic [WIDTH-1:0] exp_data;
        logic             exp_carry;
        logic             exp_zero;
        int               exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [WIDTH-1:0] d, input logic [AMT_W-1:0] a,
                            input logic [2:0] m);
        @(negedge clk);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_mode  = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = '1;
        bus.in_amt   = '1;
        bus.in_mode  = 3'd0;
    endtask

    // Cycles from the accept edge to the edge at which out_valid rises.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int j = 1; j <= 64; j++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = j;
                break;
            end
        end
        if (lat == 0) check("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] held;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{20'hABCDE, 5'd4,  3'd1, 20'h0ABCD, 1'b1, 1'b0, 5};
        vecs[1]  = '{20'h80000, 5'd3,  3'd2, 20'hF0000, 1'b0, 1'b0, 4};
        vecs[2]  = '{20'h80001, 5'd1,  3'd3, 20'h00003, 1'b1, 1'b0, 2};
        vecs[3]  = '{20'h12345, 5'd20, 3'd4, 20'h12345, 1'b0, 1'b0, 21};
        vecs[4]  = '{20'h00001, 5'd20, 3'd0, 20'h00000, 1'b1, 1'b1, 21};
        vecs[5]  = '{20'h5A5A5, 5'd0,  3'd0, 20'h5A5A5, 1'b0, 1'b0, 1};
        vecs[6]  = '{20'h5A5A5, 5'd7,  3'd7, 20'h5A5A5, 1'b0, 1'b0, 1};
        vecs[7]  = '{20'hFFFFF, 5'd31, 3'd1, 20'h00000, 1'b0, 1'b1, 32};
        vecs[8]  = '{20'hFFFFF, 5'd25, 3'd2, 20'hFFFFF, 1'b1, 1'b0, 26};
        vecs[9]  = '{20'h12345, 5'd4,  3'd3, 20'h23451, 1'b1, 1'b0, 5};
        vecs[10] = '{20'h00000, 5'd3,  3'd5, 20'h00000, 1'b0, 1'b1, 1};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_out_zero",  32'(bus.out_zero),  32'd1);
        check("rst_out_carry", 32'(bus.out_carry), 32'd0);

        foreach (vecs[i]) begin
            start_op(vecs[i].data, vecs[i].amt, vecs[i].mode);
            wait_valid(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_data", i),  32'(bus.out_data),  32'(vecs[i].exp_data));
            check($sformatf("v%0d_carry", i), 32'(bus.out_carry), 32'(vecs[i].exp_carry));
            check($sformatf("v%0d_zero", i),  32'(bus.out_zero),  32'(vecs[i].exp_zero));
            consume();
        end

        // Backpressure: result must hold while out_ready stays low.
        start_op(20'hABCDE, 5'd4, 3'd1);
        wait_valid(lat);
        held = bus.out_data;
        check("bp_data_first", 32'(held), 32'h0ABCD);
        repeat (4) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_data",      32'(bus.out_data),  32'h0ABCD);
            check("bp_carry",     32'(bus.out_carry), 32'd1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        check("bp_no_comb_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_in_ready_after", 32'(bus.in_ready),  32'd1);
        check("bp_valid_after",    32'(bus.out_valid), 32'd0);

        // Reset while a long rotate is in flight.
        start_op(20'h12345, 5'd31, 3'd4);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("mid_busy", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_data",      32'(bus.out_data),  32'h0);
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) check("mid_rst_spurious_valid", 32'd1, 32'd0);
        end
        check("mid_idle_ready", 32'(bus.in_ready), 32'd1);
        start_op(20'h00003, 5'd2, 3'd0);
        wait_valid(lat);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_data",    32'(bus.out_data),  32'h0000C);
        check("post_rst_carry",   32'(bus.out_carry), 32'd0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
